// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage: data-memory size codes,
// funct3 encodings, fault codes, FSM states and a saturating counter helper.
package lsu_pkg;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10,
    FLT_ILLEGAL  = 2'b11
  } fault_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational funct3/address decode: access size, sign extension and the
// highest-priority fault (illegal > misaligned > out of range).
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 512
) (
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic [1:0]  size,
  output logic        signext,
  output fault_t      fault
);

  logic        legal;
  logic        misaligned;
  logic [32:0] nbytes;
  logic [32:0] end_addr;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    size    = BYTE;
    signext = 1'b0;
    legal   = 1'b1;
    case (funct3)
      F3_B:  begin size = BYTE;     signext = ~is_store; end
      F3_H:  begin size = HALFWORD; signext = ~is_store; end
      F3_W:  size = WORD;
      F3_BU: if (is_store) legal = 1'b0; else size = BYTE;
      F3_HU: if (is_store) legal = 1'b0; else size = HALFWORD;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    nbytes     = 33'd1;
    misaligned = 1'b0;
    case (size)
      HALFWORD: begin nbytes = 33'd2; misaligned = addr[0];          end
      WORD:     begin nbytes = 33'd4; misaligned = (addr[1:0] != 2'b00); end
      default:  ;
    endcase
  end

  // One extra bit so addresses near 2^32 cannot wrap back into range.
  assign end_addr = {1'b0, addr} + nbytes;

  always_comb begin
    if (!legal)                            fault = FLT_ILLEGAL;
    else if (misaligned)                   fault = FLT_MISALIGN;
    else if (end_addr > 33'(MEM_DEPTH))    fault = FLT_RANGE;
    else                                   fault = FLT_NONE;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage in front of the byte-addressed data memory.
// Optional LSU_STATS_EN adds saturating load/store/fault completion counters.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MEM_DEPTH = 512,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              dm_enable,
  output logic              dm_rw,
  output logic              dm_signext,
  output logic [1:0]        dm_size,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        wb_fault
`ifdef LSU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_faults
`endif
);

  state_t     state, state_next;
  logic [1:0] dec_size;
  logic       dec_signext;
  fault_t     dec_fault;
  logic       is_store_q;

  lsu_decode #(.MEM_DEPTH(MEM_DEPTH)) u_decode (
    .is_store (req_is_store),
    .funct3   (req_funct3),
    .addr     (req_addr),
    .size     (dec_size),
    .signext  (dec_signext),
    .fault    (dec_fault)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (dec_fault == FLT_NONE) ? ACCESS : RESP;
      ACCESS:  state_next = RESP;
      RESP:    if (wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign wb_valid  = (state == RESP);

  // Faulted requests skip ACCESS and leave the dm_* fields untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dm_enable  <= 1'b0;
      dm_rw      <= 1'b0;
      dm_signext <= 1'b0;
      dm_size    <= BYTE;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_fault   <= FLT_NONE;
      is_store_q <= 1'b0;
    end else begin
      dm_enable <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          wb_rd      <= req_rd;
          wb_fault   <= dec_fault;
          wb_data    <= '0;
          is_store_q <= req_is_store;
          if (dec_fault == FLT_NONE) begin
            dm_enable  <= 1'b1;
            dm_rw      <= req_is_store;
            dm_signext <= dec_signext;
            dm_size    <= dec_size;
            dm_addr    <= req_addr[ADDR_W-1:0];
            dm_wdata   <= req_wdata;
            wb_we      <= ~req_is_store & (req_rd != 5'd0);
          end else begin
            wb_we <= 1'b0;
          end
        end
        ACCESS:  wb_data <= dm_rw ? '0 : dm_rdata;
        default: ;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_faults <= '0;
    end else if (wb_valid && wb_ready) begin
      if (wb_fault != FLT_NONE) stat_faults <= sat_inc(stat_faults);
      else if (is_store_q)      stat_stores <= sat_inc(stat_stores);
      else                      stat_loads  <= sat_inc(stat_loads);
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        dm_enable;
  logic        dm_rw;
  logic        dm_signext;
  logic [1:0]  dm_size;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_fault;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_faults;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(9), .MEM_DEPTH(512), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .dm_enable    (dm_enable),
    .dm_rw        (dm_rw),
    .dm_signext   (dm_signext),
    .dm_size      (dm_size),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_fault     (wb_fault)
`ifdef LSU_STATS_EN
    ,
    .stat_loads   (stat_loads),
    .stat_stores  (stat_stores),
    .stat_faults  (stat_faults)
`endif
  );

  // Presents one request for exactly one rising edge; returns on the falling
  // edge after acceptance (ACCESS, or RESP for a faulted request).
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    n_cmp++; if (dm_enable !== 1'b0) begin n_err++; $display("FAIL reset_dm_enable got=%b exp=0", dm_enable); end
    n_cmp++; if ({dm_rw, dm_signext, dm_size, dm_addr} !== 13'd0) begin n_err++; $display("FAIL reset_dm_fields got=%h exp=0", {dm_rw, dm_signext, dm_size, dm_addr}); end
    n_cmp++; if ({wb_we, wb_rd, wb_data, wb_fault} !== 40'd0) begin n_err++; $display("FAIL reset_wb_fields got=%h exp=0", {wb_we, wb_rd, wb_data, wb_fault}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    wb_ready = 1'b1;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd3);
    n_cmp++; if (dm_enable !== 1'b1) begin n_err++; $display("FAIL sw_dm_enable got=%b exp=1", dm_enable); end
    n_cmp++; if (dm_rw !== 1'b1) begin n_err++; $display("FAIL sw_dm_rw got=%b exp=1", dm_rw); end
    n_cmp++; if (dm_size !== 2'b10 || dm_signext !== 1'b0) begin n_err++; $display("FAIL sw_size_sext got=%b/%b exp=10/0", dm_size, dm_signext); end
    n_cmp++; if (dm_addr !== 9'h010) begin n_err++; $display("FAIL sw_dm_addr got=%h exp=010", dm_addr); end
    n_cmp++; if (dm_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_dm_wdata got=%h exp=deadbeef", dm_wdata); end
    n_cmp++; if (req_ready !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL sw_access_hs got=%b/%b exp=0/0", req_ready, wb_valid); end
    @(negedge clk);
    n_cmp++; if (dm_enable !== 1'b0) begin n_err++; $display("FAIL sw_dm_enable_drop got=%b exp=0", dm_enable); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_fault !== 2'b00 || wb_data !== 32'd0)
      begin n_err++; $display("FAIL sw_resp got=v%b we%b f%b d%h exp=v1 we0 f00 d0", wb_valid, wb_we, wb_fault, wb_data); end
    n_cmp++; if (dm_addr !== 9'h010 || dm_rw !== 1'b1) begin n_err++; $display("FAIL sw_dm_hold got=%h/%b exp=010/1", dm_addr, dm_rw); end
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL sw_idle got=%b/%b exp=0/1", wb_valid, req_ready); end
  endtask

  // Rows: funct3, addr, rd, memory word, expected signext, size, wb_we.
  task automatic test_loads();
    logic [2:0]  f3   [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
    logic [31:0] ad   [4] = '{32'h20, 32'h20, 32'h1FC, 32'h1FE};
    logic [4:0]  rd   [4] = '{5'd5, 5'd6, 5'd7, 5'd0};
    logic [31:0] rdat [4] = '{32'hFFFFFF80, 32'hFFFFFF80, 32'h12345678, 32'h0000ABCD};
    logic        sx   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz   [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
    logic        we   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dm_rdata = rdat[i];
      issue(1'b0, f3[i], ad[i], 32'h55555555, rd[i]);
      n_cmp++; if (dm_enable !== 1'b1 || dm_rw !== 1'b0) begin n_err++; $display("FAIL ld%0d_access got=%b/%b exp=1/0", i, dm_enable, dm_rw); end
      n_cmp++; if (dm_signext !== sx[i] || dm_size !== sz[i]) begin n_err++; $display("FAIL ld%0d_sext_size got=%b/%b exp=%b/%b", i, dm_signext, dm_size, sx[i], sz[i]); end
      n_cmp++; if (dm_addr !== ad[i][8:0]) begin n_err++; $display("FAIL ld%0d_dm_addr got=%h exp=%h", i, dm_addr, ad[i][8:0]); end
      @(negedge clk);
      dm_rdata = 32'h0BADF00D;
      n_cmp++; if (wb_valid !== 1'b1 || wb_fault !== 2'b00) begin n_err++; $display("FAIL ld%0d_resp got=v%b f%b exp=v1 f00", i, wb_valid, wb_fault); end
      n_cmp++; if (wb_data !== rdat[i]) begin n_err++; $display("FAIL ld%0d_wb_data got=%h exp=%h", i, wb_data, rdat[i]); end
      n_cmp++; if (wb_we !== we[i] || wb_rd !== rd[i]) begin n_err++; $display("FAIL ld%0d_we_rd got=%b/%0d exp=%b/%0d", i, wb_we, wb_rd, we[i], rd[i]); end
      @(negedge clk);
    end
  endtask

  // Rows: is_store, funct3, addr, expected fault.
  task automatic test_faults();
    logic        st [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [6] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] ad [6] = '{32'h21, 32'h1FE, 32'h200, 32'h0, 32'h0, 32'hFFFFFFFC};
    logic [1:0]  ef [6] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
    wb_ready = 1'b1;
    dm_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      issue(st[i], f3[i], ad[i], 32'h77777777, 5'd9);
      n_cmp++; if (dm_enable !== 1'b0) begin n_err++; $display("FAIL flt%0d_dm_enable got=%b exp=0", i, dm_enable); end
      n_cmp++; if (wb_valid !== 1'b1 || wb_fault !== ef[i]) begin n_err++; $display("FAIL flt%0d_code got=v%b f%b exp=v1 f%b", i, wb_valid, wb_fault, ef[i]); end
      n_cmp++; if (wb_data !== 32'd0 || wb_we !== 1'b0) begin n_err++; $display("FAIL flt%0d_data_we got=%h/%b exp=0/0", i, wb_data, wb_we); end
      @(negedge clk);
      n_cmp++; if (dm_enable !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL flt%0d_idle got=%b/%b exp=0/1", i, dm_enable, req_ready); end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    wb_ready = 1'b0;
    dm_rdata = 32'hCAFEF00D;
    issue(1'b0, 3'b010, 32'h44, 32'h0, 5'd9);
    @(negedge clk);
    dm_rdata = 32'h0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || wb_rd !== 5'd9 || wb_we !== 1'b1 ||
          wb_fault !== 2'b00 || req_ready !== 1'b0 || dm_enable !== 1'b0)
        bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_stable bad_cycles=%0d exp=0", bad); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL stall_hold got=%b/%h exp=1/cafef00d", wb_valid, wb_data); end
    wb_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0 || req_ready !== 1'b1 || dm_enable !== 1'b0) begin n_err++; $display("FAIL stall_release got=%b/%b/%b exp=0/1/0", wb_valid, req_ready, dm_enable); end
  endtask

  task automatic test_reset_mid_access();
    wb_ready = 1'b1;
    issue(1'b1, 3'b000, 32'h30, 32'h000000AA, 5'd0);
    n_cmp++; if (dm_enable !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got=%b exp=1", dm_enable); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (dm_enable !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1)
      begin n_err++; $display("FAIL rst_mid_post got=en%b v%b r%b exp=en0 v0 r1", dm_enable, wb_valid, req_ready); end
    @(negedge clk);
    n_cmp++; if (dm_enable !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_after got=%b/%b exp=0/0", dm_enable, wb_valid); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int valids = 0;
    wb_ready     = 1'b1;
    dm_rdata     = 32'h11112222;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h80;
    req_rd       = 5'd4;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (dm_enable === 1'b1) pulses++;
      if (wb_valid === 1'b1) valids++;
    end
    req_valid = 1'b0;
    n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL b2b_accesses got=%0d exp=3", pulses); end
    n_cmp++; if (valids != 3) begin n_err++; $display("FAIL b2b_responses got=%0d exp=3", valids); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || dm_enable !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b/%b exp=1/0", req_ready, dm_enable); end
  endtask

`ifdef LSU_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if ({stat_loads, stat_stores, stat_faults} !== 48'd0) begin n_err++; $display("FAIL stat_clear got=%h exp=0", {stat_loads, stat_stores, stat_faults}); end
    wb_ready = 1'b1;
    issue(1'b0, 3'b000, 32'h4, 32'h0, 5'd1); repeat (2) @(negedge clk);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 5'd0); repeat (2) @(negedge clk);
    issue(1'b1, 3'b001, 32'hC, 32'h5, 5'd0); repeat (2) @(negedge clk);
    issue(1'b0, 3'b001, 32'h3, 32'h0, 5'd2); repeat (2) @(negedge clk);
    n_cmp++; if (stat_loads !== 16'd2) begin n_err++; $display("FAIL stat_loads got=%0d exp=2", stat_loads); end
    n_cmp++; if (stat_stores !== 16'd1) begin n_err++; $display("FAIL stat_stores got=%0d exp=1", stat_stores); end
    n_cmp++; if (stat_faults !== 16'd1) begin n_err++; $display("FAIL stat_faults got=%0d exp=1", stat_faults); end
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_rd       = 5'd0;
    dm_rdata     = 32'h0;
    wb_ready     = 1'b1;
    test_reset();
    test_store_word();
    test_loads();
    test_faults();
    test_backpressure();
    test_reset_mid_access();
    test_back_to_back();
`ifdef LSU_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store control stage directly upstream of the byte-addressed data memory in the PPU's MEM stage. Accepts one EX/MEM load or store request at a time and decodes RISC-V funct3. Drives the data memory control pins (Enable, ReadWrite, SignExt, Size, Address, DataIn), checks alignment and range, and returns a registered result/completion to WB over a valid/ready handshake.

Parameters:
ADDR_W, 9, data-memory address width (byte address)
MEM_DEPTH, 512, data-memory size in bytes
DATA_W, 32, data path width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  EX/MEM request present
req_ready  out  1  block can accept request (IDLE only)
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 of load/store
req_addr  in  32  effective byte address
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register
dm_enable  out  1  data memory Enable
dm_rw  out  1  data memory ReadWrite (1=write)
dm_signext  out  1  data memory SignExt
dm_size  out  2  data memory Size: 00 byte, 01 half, 10 word
dm_addr  out  ADDR_W  data memory Address
dm_wdata  out  32  data memory DataIn
dm_rdata  in  32  data memory DataOut (combinational read)
wb_valid  out  1  result/completion valid
wb_ready  in  1  WB consumes result
wb_we  out  1  register write enable (load, rd!=0, no fault)
wb_rd  out  5  destination register
wb_data  out  32  load data; 0 for stores/faults
wb_fault  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal funct3

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0 except req_ready=1; any in-flight request dropped; no dm write issued from the cycle after reset.
- FSM states IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: latch request, decode, and check faults.
  - No fault: go to ACCESS.
  - Fault: go to RESP with wb_fault set, wb_data=0, wb_we=0; dm_enable never asserted.
- Decode, loads: 000 LB (size 00, signext 1); 001 LH (01, 1); 010 LW (10, 0); 100 LBU (00, 0); 101 LHU (01, 0).
- Decode, stores: 000 SB; 001 SH; 010 SW. dm_signext=0 for stores.
- Any other funct3: fault 11.
- Fault priority: illegal > misaligned > range.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Range: addr + bytes > MEM_DEPTH (compare full 32-bit address; upper bits nonzero means range fault).
- ACCESS: exactly one cycle.
  - dm_enable=1; dm_rw=is_store; dm_size, dm_signext, dm_addr=addr[ADDR_W-1:0], dm_wdata=wdata all held stable from registers.
  - For loads, capture dm_rdata at the end of the cycle into wb_data. For stores, wb_data=0.
  - Next state RESP.
- RESP: dm_enable=0; wb_valid=1 with wb_rd, wb_we, wb_data, wb_fault held stable until wb_ready=1 at a clk edge, then IDLE. req_ready=0.
- Latency: accepted at edge N → dm_enable high cycle N+1 → wb_valid high from cycle N+2. Throughput: at most one request per 3 cycles with wb_ready tied high.
- All dm_* outputs are registered; dm_* fields other than dm_enable hold their last values when dm_enable=0.
- Stores produce wb_valid with wb_we=0 (completion only).
- Fault in one request does not block later requests.

Optional Feature:
LSU_STATS_EN:
- Defined: adds outputs stat_loads, stat_stores, stat_faults (16 bits each).
  - Each counter increments once on the wb_valid&wb_ready handshake of the matching kind; a faulted request counts only in stat_faults.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package lsu_pkg holds:
  - size constants BYTE=2'b00, HALFWORD=2'b01, WORD=2'b10 (same encoding as the data memory);
  - funct3 constants F3_B/H/W/BU/HU;
  - fault enum FLT_NONE/MISALIGN/RANGE/ILLEGAL;
  - FSM state typedef.
- One sub-module, lsu_decode: purely combinational funct3/address → size, signext, fault. Instantiated once.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF → one cycle dm_enable=1, dm_rw=1, dm_size=10, dm_addr=0x10, dm_wdata=0xDEADBEEF; then wb_valid, wb_we=0, wb_fault=00.
- LB addr 0x20 rd=5, dm_rdata=0xFFFFFF80 during ACCESS → wb_data=0xFFFFFF80, dm_signext=1, wb_we=1, wb_rd=5; LBU same → dm_signext=0.
- LH addr 0x21 → wb_fault=01, dm_enable never 1, wb_data=0. LW addr 0x1FE → wb_fault=01. LW addr 0x200 → wb_fault=10. funct3=011 → wb_fault=11.
- Load with rd=0 → wb_we=0. wb_ready held low 5 cycles → wb_* stable and req_ready=0 throughout; release → IDLE next cycle.
- rst_n low during ACCESS of a store → dm_enable=0 from the next cycle, wb_valid=0, req_ready=1 after reset.
- LSU_STATS_EN: 2 loads, 1 store, 1 fault → stat_loads=2, stat_stores=1, stat_faults=1.
